vce2_vrf_seq: RTL and testbench
===============================

// Module: vce2_vrf_seq
// PURPOSE
//  Beat sequencer for vector element-wise ops. Drives the vector AGU's control side
//  (load / get_rs1 / get_rs2 / get_rd) and the VRF memory port's data side.
//  Flow per op: one AGU load, then per 32-bit word: read rs1, optionally read rs2,
//  hand the operands to the lane ALU, then write the result to rd.
//  Sits between the coprocessor issue logic and the AGU + VRF SRAM; the AGU drives the address.
// PARAMETERS
//  DataWidth  32  word width of VRF SRAM and lane datapath
//  VLenWords  4   words per vector register (beats per op); >=2, power of two
// PORTS
//  clk_i                  in   1          clock
//  rst_ni                 in   1          async reset, active low
//  start_i                in   1          issue op; sampled only in IDLE
//  two_src_i              in   1          op reads rs2; sampled with start_i
//  busy_o                 out  1          high in every state except IDLE
//  done_o                 out  1          one-cycle pulse when the op completes
//  agu_load_o             out  1          AGU parallel-load request
//  agu_ready_i            in   1          AGU address load complete (1-cycle pulse)
//  agu_get_rs1_o          out  1          AGU: present rs1 address, post-increment
//  agu_get_rs2_o          out  1          AGU: present rs2 address, post-increment
//  agu_get_rd_o           out  1          AGU: present rd address, post-increment
//  agu_get_rd_noincr_o    out  1          tied 0 (reserved for accumulate ops)
//  mem_req_o              out  1          VRF SRAM access strobe
//  mem_we_o               out  1          1 = write, 0 = read
//  mem_wdata_o            out  DataWidth  write data
//  mem_rdata_i            in   DataWidth  read data; valid the cycle after a read req
//  op_a_o                 out  DataWidth  lane operand A (rs1 word)
//  op_b_o                 out  DataWidth  lane operand B (rs2 word, 0 if !two_src)
//  op_valid_o             out  1          operands valid; held until res_valid_i
//  res_valid_i            in   1          lane result valid; may be same cycle as op_valid_o
//  res_i                  in   DataWidth  lane result
// BEHAVIOUR
//  Reset (async): state IDLE; beat_cnt, op_a_q, op_b_q, res_q and two_src_q = 0; all outputs 0.
//  Reset mid-op aborts with no further mem/AGU strobes.
//  SRAM is always ready: each access is exactly one cycle with mem_req_o high,
//  and exactly one agu_get_* is high in that same cycle. No agu_get_* without mem_req_o.
//  States:
//  - IDLE: start_i=1 -> LOAD, latch two_src_i. Otherwise stay.
//  - LOAD: agu_load_o=1 for exactly one cycle -> WAIT_AGU.
//  - WAIT_AGU: stay until agu_ready_i=1 -> RD_A. With the current AGU this is 3 cycles.
//  - RD_A: mem_req_o=1, we=0, agu_get_rs1_o=1 -> RD_B.
//  - RD_B: op_a_q <= mem_rdata_i.
//    If two_src_q: mem_req_o=1, we=0, agu_get_rs2_o=1 -> CAP_B.
//    Else: op_b_q <= 0 -> EXEC.
//  - CAP_B: op_b_q <= mem_rdata_i -> EXEC.
//  - EXEC: op_valid_o=1; op_a_o/op_b_o = op_a_q/op_b_q, stable.
//    On res_valid_i: res_q <= res_i -> WR. res_valid_i outside EXEC is ignored.
//  - WR: mem_req_o=1, we=1, agu_get_rd_o=1, mem_wdata_o=res_q.
//    If beat_cnt==VLenWords-1: beat_cnt<=0 -> DONE. Else beat_cnt++ -> RD_A.
//  - DONE: done_o=1 for one cycle -> IDLE.
//  - Illegal encodings -> IDLE.
//  start_i outside IDLE is ignored (not queued). start_i in the DONE cycle is ignored.
//  beat_cnt is $clog2(VLenWords) bits wide; its wrap coincides with leaving WR on the last beat.
//  Latency (zero-wait lane): 5 cycles/beat with two_src, 4 cycles/beat without.
//  Start to done_o = 4 + 1 + beats*cyc_per_beat cycles.
//  mem_wdata_o = 0 outside WR. op_a_o/op_b_o = 0 outside EXEC.
// TESTING
//  1. VLenWords=4, two_src=1, start at cycle 0, lane answers same cycle as op_valid_o:
//     agu_load_o at 1, first RD_A at 5, done_o at 25; 12 mem_req, 4 of them writes.
//  2. two_src=0, rs1 words {1,2,3,4}, lane returns a+1:
//     writes {2,3,4,5}, agu_get_rs2_o never high, op_b_o=0, done_o at 21.
//  3. Lane stalls 3 cycles on beat 1: op_valid_o held 4 cycles with stable op_a_o/op_b_o;
//     no mem_req_o during the stall; done_o delayed by exactly 3 cycles.
//  4. start_i pulsed during RD_B and during DONE: ignored; exactly one done_o; next start_i
//     in IDLE runs a fresh op.
//  5. rst_ni low in EXEC of beat 2: all outputs 0 immediately; after release stays IDLE;
//     next op begins with agu_load_o.
//  6. agu_ready_i held off 10 cycles: FSM waits in WAIT_AGU with no mem_req_o;
//     RD_A in the cycle after ready.

Source files
------------

// File: rtl/vce2_vrf_seq.sv
// Beat sequencer for element-wise vector ops: one AGU load, then per word
// read rs1 (and optionally rs2), hand operands to the lane, write the result to rd.
module vce2_vrf_seq #(
  parameter int DataWidth = 32,
  parameter int VLenWords = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 two_src_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 agu_load_o,
  input  logic                 agu_ready_i,
  output logic                 agu_get_rs1_o,
  output logic                 agu_get_rs2_o,
  output logic                 agu_get_rd_o,
  output logic                 agu_get_rd_noincr_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic [DataWidth-1:0] op_a_o,
  output logic [DataWidth-1:0] op_b_o,
  output logic                 op_valid_o,
  input  logic                 res_valid_i,
  input  logic [DataWidth-1:0] res_i
);
  localparam int CntW = $clog2(VLenWords);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LOAD  = 4'd1;
  localparam logic [3:0] S_WAIT  = 4'd2;
  localparam logic [3:0] S_RD_A  = 4'd3;
  localparam logic [3:0] S_RD_B  = 4'd4;
  localparam logic [3:0] S_CAP_B = 4'd5;
  localparam logic [3:0] S_EXEC  = 4'd6;
  localparam logic [3:0] S_WR    = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  logic [3:0]           state_q, state_d;
  logic [CntW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [DataWidth-1:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic                 two_src_q, two_src_d;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    res_d      = res_q;
    two_src_d  = two_src_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d   = S_LOAD;
        two_src_d = two_src_i;
      end
      S_LOAD: state_d = S_WAIT;
      S_WAIT: if (agu_ready_i) state_d = S_RD_A;
      S_RD_A: state_d = S_RD_B;
      // rs1 data returns here, the same cycle the optional rs2 read is issued
      S_RD_B: begin
        op_a_d = mem_rdata_i;
        if (two_src_q) begin
          state_d = S_CAP_B;
        end else begin
          op_b_d  = '0;
          state_d = S_EXEC;
        end
      end
      S_CAP_B: begin
        op_b_d  = mem_rdata_i;
        state_d = S_EXEC;
      end
      S_EXEC: if (res_valid_i) begin
        res_d   = res_i;
        state_d = S_WR;
      end
      S_WR: begin
        if (beat_cnt_q == CntW'(VLenWords - 1)) begin
          beat_cnt_d = '0;
          state_d    = S_DONE;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          state_d    = S_RD_A;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_q      <= '0;
      two_src_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      res_q      <= res_d;
      two_src_q  <= two_src_d;
    end
  end

  // Outputs decode purely from state so an async reset clears them at once.
  logic in_rd_b2;
  assign in_rd_b2 = (state_q == S_RD_B) && two_src_q;

  assign busy_o              = (state_q != S_IDLE);
  assign done_o              = (state_q == S_DONE);
  assign agu_load_o          = (state_q == S_LOAD);
  assign agu_get_rs1_o       = (state_q == S_RD_A);
  assign agu_get_rs2_o       = in_rd_b2;
  assign agu_get_rd_o        = (state_q == S_WR);
  assign agu_get_rd_noincr_o = 1'b0;
  assign mem_req_o           = (state_q == S_RD_A) || in_rd_b2 || (state_q == S_WR);
  assign mem_we_o            = (state_q == S_WR);
  assign mem_wdata_o         = (state_q == S_WR) ? res_q : '0;
  assign op_valid_o          = (state_q == S_EXEC);
  assign op_a_o              = (state_q == S_EXEC) ? op_a_q : '0;
  assign op_b_o              = (state_q == S_EXEC) ? op_b_q : '0;

endmodule

// File: tb/tb_vce2_vrf_seq.sv
// Bench for vce2_vrf_seq: AGU, SRAM and lane models around the sequencer,
// expected write data queued per op and popped on each SRAM write.
module tb_vce2_vrf_seq;
  localparam int DW = 32;
  localparam int VL = 4;
  localparam int PW = $clog2(VL);

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          start_i, two_src_i, agu_ready_i, res_valid_i;
  logic [DW-1:0] mem_rdata_i, res_i;
  logic          busy_o, done_o, agu_load_o, agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o;
  logic          agu_get_rd_noincr_o, mem_req_o, mem_we_o, op_valid_o;
  logic [DW-1:0] mem_wdata_o, op_a_o, op_b_o;

  always #5 clk = ~clk;

  vce2_vrf_seq #(.DataWidth(DW), .VLenWords(VL)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .two_src_i(two_src_i),
    .busy_o(busy_o), .done_o(done_o), .agu_load_o(agu_load_o), .agu_ready_i(agu_ready_i),
    .agu_get_rs1_o(agu_get_rs1_o), .agu_get_rs2_o(agu_get_rs2_o), .agu_get_rd_o(agu_get_rd_o),
    .agu_get_rd_noincr_o(agu_get_rd_noincr_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .op_a_o(op_a_o), .op_b_o(op_b_o),
    .op_valid_o(op_valid_o), .res_valid_i(res_valid_i), .res_i(res_i)
  );

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stimulus knobs, written only by the main initial block
  int       t0 = 0;
  bit       cur_ts = 1'b0;
  int       agu_delay = 3;
  int       stall_beat = -1;
  int       stall_n = 0;
  logic [DW-1:0] rf1 [VL];
  logic [DW-1:0] rf2 [VL];
  logic [DW-1:0] sbq [$];

  // AGU: ready pulses agu_delay cycles after the load cycle
  int agu_cnt = 0;
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)         agu_cnt <= 0;
    else if (agu_load_o) agu_cnt <= agu_delay;
    else if (agu_cnt > 0) agu_cnt <= agu_cnt - 1;
  end
  assign agu_ready_i = (agu_cnt == 1);

  // SRAM: one-cycle read latency, garbage on the bus when not read
  logic [PW-1:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    mem_rdata_i <= $urandom;
    if (agu_load_o) begin
      p1 <= '0;
      p2 <= '0;
    end else if (mem_req_o && !mem_we_o) begin
      if (agu_get_rs1_o) begin
        mem_rdata_i <= rf1[p1];
        p1 <= p1 + 1'b1;
      end else if (agu_get_rs2_o) begin
        mem_rdata_i <= rf2[p2];
        p2 <= p2 + 1'b1;
      end
    end
  end

  // Lane: res = a + b + 1, optional stall on one beat, noise on res_valid outside EXEC
  int   lane_beat = 0;
  int   lane_wait = 0;
  logic noise = 1'b0;
  logic lane_ok;
  assign lane_ok     = !(lane_beat == stall_beat && lane_wait < stall_n);
  assign res_valid_i = op_valid_o ? lane_ok : noise;
  assign res_i       = op_a_o + op_b_o + 32'd1;
  always @(posedge clk) begin
    noise <= 1'($urandom);
    if (agu_load_o) begin
      lane_beat <= 0;
      lane_wait <= 0;
    end else if (op_valid_o) begin
      if (res_valid_i) begin
        lane_beat <= lane_beat + 1;
        lane_wait <= 0;
      end else begin
        lane_wait <= lane_wait + 1;
      end
    end
  end

  // Monitor
  int            load_cyc = -1, first_cyc = -1, done_cyc = -1;
  int            n_req = 0, n_wr = 0, n_done = 0, ov_run = 0;
  bit            first_seen = 1'b0;
  logic [DW-1:0] hold_a = '0, hold_b = '0;
  logic [2:0]    gets;
  assign gets = {agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o};

  always @(negedge clk) begin
    if (agu_load_o) begin
      load_cyc   <= cyc;
      first_seen <= 1'b0;
      n_req      <= 0;
      n_wr       <= 0;
      n_done     <= 0;
    end else begin
      if (mem_req_o) n_req <= n_req + 1;
      if (mem_req_o && mem_we_o) n_wr <= n_wr + 1;
      if (done_o) begin
        n_done   <= n_done + 1;
        done_cyc <= cyc;
      end
      if (mem_req_o && !first_seen) begin
        first_seen <= 1'b1;
        first_cyc  <= cyc;
        chk("first_is_rs1", agu_get_rs1_o, 1);
      end
    end
    if (mem_req_o) chk("get_onehot", $countones(gets), 1);
    else if (gets != 3'b0) chk("get_without_req", gets, 0);
    if (agu_get_rd_noincr_o) chk("rd_noincr", agu_get_rd_noincr_o, 0);
    if (!(mem_req_o && mem_we_o) && mem_wdata_o != '0) chk("wdata_idle", mem_wdata_o, 0);
    if (agu_get_rs2_o) chk("rs2_get", agu_get_rs2_o, cur_ts);
    if (mem_req_o && mem_we_o) begin
      chk("wr_get_rd", agu_get_rd_o, 1);
      if (sbq.size() > 0) chk("wdata", mem_wdata_o, sbq.pop_front());
      else chk("wr_extra", sbq.size(), 1);
    end
    if (op_valid_o) begin
      if (mem_req_o) chk("req_in_exec", mem_req_o, 0);
      if (!cur_ts) chk("opb_zero", op_b_o, 0);
      if (ov_run > 0) begin
        chk("opa_hold", op_a_o, hold_a);
        chk("opb_hold", op_b_o, hold_b);
      end
      hold_a <= op_a_o;
      hold_b <= op_b_o;
      if (res_valid_i) begin
        chk("ov_len", ov_run + 1, (lane_beat == stall_beat) ? stall_n + 1 : 1);
        ov_run <= 0;
      end else begin
        ov_run <= ov_run + 1;
      end
    end else begin
      ov_run <= 0;
      if ((op_a_o | op_b_o) != '0) chk("op_idle", op_a_o | op_b_o, 0);
    end
  end

  logic [DW-1:0] any_out;
  assign any_out = mem_wdata_o | op_a_o | op_b_o |
                   {{(DW-1){1'b0}}, busy_o | done_o | agu_load_o | agu_get_rs1_o |
                    agu_get_rs2_o | agu_get_rd_o | agu_get_rd_noincr_o | mem_req_o |
                    mem_we_o | op_valid_o};

  task automatic run_op(input bit ts, input int dly, input int sbeat, input int sn,
                        input int abort_beat, input bit seqd, input bit pulse);
    int exp_done;
    cur_ts     = ts;
    agu_delay  = dly;
    stall_beat = sbeat;
    stall_n    = sn;
    sbq.delete();
    for (int i = 0; i < VL; i++) begin
      rf1[i] = seqd ? DW'(i + 1) : DW'($urandom);
      rf2[i] = DW'($urandom);
      sbq.push_back(rf1[i] + (ts ? rf2[i] : '0) + 32'd1);
    end
    exp_done = dly + 2 + VL * (ts ? 5 : 4) + ((sbeat >= 0) ? sn : 0);
    @(posedge clk); #1;
    start_i   = 1'b1;
    two_src_i = ts;
    t0        = cyc;
    @(posedge clk); #1;
    start_i   = 1'b0;
    two_src_i = !ts;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (pulse) start_i = ((cyc - t0) == dly + 3) || ((cyc - t0) == exp_done);
      if (abort_beat >= 0 && op_valid_o && lane_beat == abort_beat) begin
        rst_ni = 1'b0;
        #1;
        chk("rst_outs", any_out, 0);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("post_rst_idle", busy_o | mem_req_o | agu_load_o, 0);
        end
        return;
      end
      if (done_cyc > t0) break;
    end
    @(negedge clk); #1;
    start_i = 1'b0;
    chk("idle_after", busy_o, 0);
    @(negedge clk);
    chk("still_idle", busy_o, 0);
    chk("load_at", load_cyc - t0, 1);
    chk("first_rd_at", first_cyc - t0, dly + 2);
    chk("done_at", done_cyc - t0, exp_done);
    chk("n_req", n_req, VL * (ts ? 3 : 2));
    chk("n_wr", n_wr, VL);
    chk("n_done", n_done, 1);
    chk("sb_empty", sbq.size(), 0);
  endtask

  initial begin
    rst_ni    = 1'b0;
    start_i   = 1'b0;
    two_src_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", any_out, 0);
    rst_ni = 1'b1;
    run_op(1'b1, 3, -1, 0, -1, 1'b0, 1'b0);  // two_src baseline: done at 25
    run_op(1'b0, 3, -1, 0, -1, 1'b1, 1'b0);  // single source, {1,2,3,4} -> {2,3,4,5}
    run_op(1'b1, 3,  1, 3, -1, 1'b0, 1'b0);  // lane stall on beat 1
    run_op(1'b0, 3, -1, 0, -1, 1'b0, 1'b1);  // start pulses in RD_B and DONE
    run_op(1'b1, 3, -1, 0,  2, 1'b0, 1'b0);  // reset in EXEC of beat 2
    run_op(1'b0, 3, -1, 0, -1, 1'b0, 1'b0);  // fresh op after abort
    run_op(1'b1, 13, -1, 0, -1, 1'b0, 1'b0); // slow AGU ready
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
